// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128/192/256 key schedule, one word per clock.
// Build option AES_KEYEXP_ZEROIZE_EN clears every round-key slot on LOAD.
module aes_key_expand #(
  parameter int MAXRK = 15,
  parameter int WIN   = 8
) (
  input  logic                    eph1,
  input  logic                    reset,
  input  logic                    start,
  input  logic [255:0]            key_i,
  input  logic [1:0]              key_size_i,
  output logic                    busy_o,
  output logic                    ready_o,
  output logic [MAXRK:1][127:0]   key_words_o
);

  localparam int WB = $clog2(WIN);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t                 state_q;
  state_t                 state_d;
  logic                   load;
  logic                   step;
  logic                   last;

  logic [3:0]             nk_q;
  logic [5:0]             wtot_q;
  logic [5:0]             i_q;
  logic [2:0]             kmod_q;
  logic [7:0]             rcon_q;
  logic [WIN-1:0][31:0]   win_q;

  logic [3:0]             size_nk;
  logic [5:0]             size_w;
  logic [7:0][31:0]       kw;
  logic [WIN-1:0][31:0]   win_load;

  logic [31:0]            prev;
  logic [31:0]            far;
  logic                   rot_sel;
  logic [31:0]            sub_in;
  logic [31:0]            sub_out;
  logic [31:0]            t;
  logic [31:0]            wnew;
  logic [3:0]             slot;
  logic [6:0]             lane;

  // Key geometry from the requested size.
  always_comb begin
    size_nk = 4'd8;
    size_w  = 6'd60;
    unique case (1'b1)
      key_size_i == 2'b00: begin
        size_nk = 4'd4;
        size_w  = 6'd44;
      end
      key_size_i == 2'b01: begin
        size_nk = 4'd6;
        size_w  = 6'd52;
      end
      key_size_i[1]: begin
        size_nk = 4'd8;
        size_w  = 6'd60;
      end
    endcase
  end

  // Split the MSB-aligned key into words; newest key word lands in window slot 0.
  always_comb begin
    kw       = '0;
    win_load = '0;
    for (int j = 0; j < 8; j++)
      kw[j] = key_i[255-32*j -: 32];
    for (int k = 0; k < WIN; k++)
      if (k < int'(size_nk))
        win_load[k] = kw[3'(int'(size_nk) - 1 - k)];
  end

  assign prev    = win_q[0];
  assign far     = win_q[WB'(nk_q - 4'd1)];
  assign rot_sel = (kmod_q == 3'd0);
  assign sub_in  = rot_sel ? {prev[23:0], prev[31:24]} : prev;
  assign sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                    SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};
  assign slot    = 4'(MAXRK) - i_q[5:2];
  assign lane    = {~i_q[1:0], 5'b0};
  assign last    = (i_q == wtot_q - 6'd1);
  assign wnew    = far ^ t;

  // Select the schedule transform for the current word position.
  always_comb begin
    t = prev;
    if (rot_sel)
      t = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && kmod_q == 3'd4)
      t = sub_out;
  end

  // State register.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; any sampled start restarts from LOAD.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    if (start) begin
      load    = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          step = 1'b1;
          if (last) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Status flags.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
    end else if (load) begin
      busy_o  <= 1'b1;
      ready_o <= 1'b0;
    end else if (step && last) begin
      busy_o  <= 1'b0;
      ready_o <= 1'b1;
    end
  end

  // Schedule datapath: load key words, then produce one word per edge.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      nk_q        <= 4'd0;
      wtot_q      <= 6'd0;
      i_q         <= 6'd0;
      kmod_q      <= 3'd0;
      rcon_q      <= 8'h01;
      win_q       <= '0;
      key_words_o <= '0;
    end else if (load) begin
      nk_q   <= size_nk;
      wtot_q <= size_w;
      i_q    <= 6'(size_nk);
      kmod_q <= 3'd0;
      rcon_q <= 8'h01;
      win_q  <= win_load;
`ifdef AES_KEYEXP_ZEROIZE_EN
      key_words_o <= '0;
`endif
      key_words_o[MAXRK] <= key_i[255:128];
      if (size_nk != 4'd4)
        key_words_o[MAXRK-1][127:64] <= key_i[127:64];
      if (size_nk == 4'd8)
        key_words_o[MAXRK-1][63:0] <= key_i[63:0];
    end else if (step) begin
      key_words_o[slot][lane +: 32] <= wnew;
      win_q  <= {win_q[WIN-2:0], wnew};
      i_q    <= i_q + 6'd1;
      kmod_q <= (kmod_q == 3'(nk_q - 4'd1)) ? 3'd0 : kmod_q + 3'd1;
      if (rot_sel) rcon_q <= xtime(rcon_q);
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: scoreboard bench for the AES key schedule.
// Expected schedules come from a GF(2^8) arithmetic model of FIPS-197.
module tb_aes_key_expand;

  logic                eph1 = 1'b0;
  logic                reset;
  logic                start;
  logic [255:0]        key_i;
  logic [1:0]          key_size_i;
  logic                busy_o;
  logic                ready_o;
  logic [15:1][127:0]  key_words_o;

  aes_key_expand dut (
    .eph1        (eph1),
    .reset       (reset),
    .start       (start),
    .key_i       (key_i),
    .key_size_i  (key_size_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .key_words_o (key_words_o)
  );

  always #5 eph1 = ~eph1;

`ifdef AES_KEYEXP_ZEROIZE_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] S1_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge eph1) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
            ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r = 8'h01;
    for (int j = 1; j < n; j++) r = gmul(r, 8'h02);
    return r;
  endfunction

  logic [31:0] nw_arr [60];
  logic [31:0] pw_arr [60];
  int n_nk, n_nw, p_nk, p_nw, p_load;
  bit have_prev = 1'b0;
  logic [15:1][127:0] mdl = '0;

  function automatic void expand(input logic [255:0] k, input logic [1:0] sz);
    logic [31:0] t;
    n_nk = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 6 : 8;
    n_nw = 4 * (n_nk + 7);
    for (int j = 0; j < 60; j++) nw_arr[j] = 32'h0;
    for (int j = 0; j < n_nk; j++) nw_arr[j] = k[255-32*j -: 32];
    for (int i = n_nk; i < n_nw; i++) begin
      t = nw_arr[i-1];
      if (i % n_nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon(i / n_nk), 24'h0};
      else if (n_nk == 8 && i % 8 == 4)
        t = subw(t);
      nw_arr[i] = nw_arr[i-n_nk] ^ t;
    end
  endfunction

  function automatic void put_prev(input int cnt);
    for (int j = 0; j < cnt; j++)
      mdl[15-j/4][127-32*(j%4) -: 32] = pw_arr[j];
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:1][127:0] kw;
    int                 done_cyc;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;
  logic ready_q = 1'b0;

  // Monitor: every rising ready_o retires one expected schedule.
  always @(negedge eph1) begin
    if (ready_o && !ready_q) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL spurious_ready cyc=%0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (cyc != mon_e.done_cyc) begin
          bad++;
          $display("FAIL latency got_edge=%0d want_edge=%0d", cyc, mon_e.done_cyc);
        end
        for (int s = 1; s <= 15; s++) begin
          total++;
          if (key_words_o[s] !== mon_e.kw[s]) begin
            bad++;
            $display("FAIL slot%0d got=%h want=%h", s, key_words_o[s], mon_e.kw[s]);
          end
        end
      end
    end
    ready_q = ready_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [255:0] k, input logic [1:0] sz);
    exp_t e;
    int c;
    int n;
    @(negedge eph1);
    c = cyc;
    if (have_prev) begin
      n = p_nk + (c - p_load);
      if (n > p_nw) n = p_nw;
      put_prev(n);
    end
    if (ZERO) mdl = '0;
    expand(k, sz);
    e.kw = mdl;
    for (int j = 0; j < n_nw; j++)
      e.kw[15-j/4][127-32*(j%4) -: 32] = nw_arr[j];
    e.done_cyc = c + 1 + (n_nw - n_nk);
    sbq.delete();
    sbq.push_back(e);
    for (int j = 0; j < 60; j++) pw_arr[j] = nw_arr[j];
    p_nk = n_nk;
    p_nw = n_nw;
    p_load = c + 1;
    have_prev = 1'b1;
    key_i = k;
    key_size_i = sz;
    start = 1'b1;
    @(negedge eph1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge eph1);
      #1;
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s timeout ready_o=%0b busy_o=%0b", nm, ready_o, busy_o);
      sbq.delete();
    end
  endtask

  function automatic logic [255:0] rkey();
    logic [255:0] k = '0;
    for (int j = 0; j < 8; j++) k = {k[223:0], 32'($urandom)};
    return k;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    key_i = '0;
    key_size_i = 2'b00;
    build_sbox();
    repeat (3) @(negedge eph1);
    #1;
    chk("rst_busy", 128'(busy_o), 128'h0);
    chk("rst_ready", 128'(ready_o), 128'h0);
    for (int s = 1; s <= 15; s++) chk($sformatf("rst_slot%0d", s), key_words_o[s], 128'h0);
    @(negedge eph1);
    reset = 1'b1;

    // FIPS-197 128-bit vector; latency counts the LOAD edge as edge 1.
    issue({K128, 128'h0}, 2'b00);
    wait_done("k128");
    chk("k128_s15", key_words_o[15], K128);
    chk("k128_s14", key_words_o[14], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("k128_s5", key_words_o[5], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("k128_busy", 128'(busy_o), 128'h0);

    // 192-bit vector with junk in the ignored low bits.
    issue({K192, 64'hdead_beef_0123_4567}, 2'b01);
    wait_done("k192");
    chk("k192_s3", key_words_o[3], 128'he98ba06f448c773c8ecc720401002202);

    issue(K256, 2'b11);
    wait_done("k256_11");
    chk("k256_11_s1", key_words_o[1], S1_256);
    issue(K256, 2'b10);
    wait_done("k256_10");
    chk("k256_10_s1", key_words_o[1], S1_256);

    // Restart from DONE with a shorter key.
    issue({rkey()}, 2'b00);
    #1;
    chk("restart_ready_drop", 128'(ready_o), 128'h0);
    chk("restart_busy", 128'(busy_o), 128'h1);
    wait_done("restart128");
    chk("stale_s1", key_words_o[1], ZERO ? 128'h0 : S1_256);

    // Abort a 256-bit run ten cycles in with the FIPS 128-bit key.
    issue(rkey(), 2'b11);
    repeat (9) @(negedge eph1);
    issue({K128, 128'h0}, 2'b00);
    wait_done("abort128");
    chk("abort_s5", key_words_o[5], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Asynchronous reset between edges during RUN.
    issue(rkey(), 2'b10);
    repeat (5) @(negedge eph1);
    @(posedge eph1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy_o), 128'h0);
    chk("midrst_ready", 128'(ready_o), 128'h0);
    chk("midrst_s15", key_words_o[15], 128'h0);
    chk("midrst_s14", key_words_o[14], 128'h0);
    chk("midrst_s13", key_words_o[13], 128'h0);
    sbq.delete();
    have_prev = 1'b0;
    mdl = '0;
    @(negedge eph1);
    reset = 1'b1;
    issue(rkey(), 2'b00);
    wait_done("post_reset");

    // Randomized sizes, keys and occasional mid-run restarts.
    for (int r = 0; r < 14; r++) begin
      issue(rkey(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 10)) @(negedge eph1);
        issue(rkey(), 2'($urandom_range(0, 3)));
      end
      wait_done($sformatf("rand%0d", r));
    end

    repeat (2) @(negedge eph1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Upstream stage of the AES encrypt and decrypt rounds.
- Expands a 128/192/256-bit cipher key into the round-key array consumed on the rounds' key_words_i inputs, and raises the ready flag they wait on.
- Iterative: one 32-bit schedule word per clock, with a single SubWord S-box bank.
- Replaces the hard-wired key_words and ready stimulus used by the current top.

Parameters:
- MAXRK, 15, number of 128-bit round-key slots on key_words_o (indices MAXRK:1).
- WIN, 8, depth of the sliding word window, which must be at least the largest Nk.

Ports:
- eph1  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that samples key_i and key_size_i and begins expansion.
- key_i  in  256  cipher key, MSB-aligned: 128-bit key in [255:128], 192-bit key in [255:64], 256-bit key in [255:0]; unused low bits are ignored.
- key_size_i  in  2  00 = 128-bit, 01 = 192-bit, 10/11 = 256-bit.
- busy_o  out  1  expansion in progress.
- ready_o  out  1  key_words_o is complete and valid; drives the rounds' ready_i.
- key_words_o  out  [15:1][127:0]  round keys. Index 15 = round 0 (the raw key's first 128 bits). Within a slot, word 0 is at [127:96].

Behaviour:
- Reset (reset low, asynchronous): busy_o=0, ready_o=0, key_words_o all zero, FSM to IDLE, word counter 0.
- Key geometry: Nk = 4/6/8 and Nr = 10/12/14. Total words W = 4*(Nr+1) = 44/52/60.
- Schedule word i is stored at key_words_o[15 - i/4], word lane i%4.
- FSM IDLE:
  - start=1 → LOAD edge: the Nk key words are written to words 0..Nk-1 and to the window; i=Nk; busy_o=1; ready_o=0. Next state RUN.
- FSM RUN, one word per edge:
  - t = w[i-1].
  - If i%Nk==0: t = SubWord(RotWord(t)) ^ {Rcon[i/Nk],24'h0}.
  - Else if Nk==8 and i%8==4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t. The window shifts and w[i] is stored.
  - When i==W-1 the word is stored; next state DONE, busy_o=0, ready_o=1.
- Rcon is produced by a byte register starting at 01, doubled in GF(2^8) (xtime, poly 11B) after each use; it reaches 36 for its 10th value. No ROM.
- Latency: ready_o is high after the N-th rising edge following the edge that samples start, where N = 1 + (W - Nk) = 41/47/53 for 128/192/256.
- DONE: ready_o holds high and key_words_o is stable until the next start or reset.
- start in DONE: restart exactly as from IDLE. ready_o drops on the LOAD edge.
- start in RUN: abort the current expansion and restart with the new key/size. Partially written slots are overwritten by the new schedule as it proceeds.
- start held high for several cycles: each sampled high restarts. The driver must pulse.
- Unused slots, i.e. index < 15-Nr (slots 4:1 for 128-bit, 2:1 for 192-bit): see Optional Feature.
- key_words_o slots change only on LOAD/RUN edges; consumers sample only while ready_o=1.
- Reset mid-RUN: immediate return to the reset state; no partial ready.

Optional Feature:
- Macro: AES_KEYEXP_ZEROIZE_EN.
- Defined: the LOAD edge clears all 15 slots to zero before the key words are written. Unused slots therefore read zero, and no previous key material survives a restart.
- Undefined: slots are written only as words are produced. Unused slots keep stale values from a previous longer key, and a mid-RUN restart leaves prior words in place until overwritten.
- Both builds must give identical used slots and identical latency.

Test Plan:
- 128-bit key 2b7e151628aed2a6abf7158809cf4f3c, start pulse → ready_o high after 41 edges.
  - key_words_o[15] = key, key_words_o[14] = a0fafe1788542cb123a339392a6c7605, key_words_o[5] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Slots 4:1 are zero when AES_KEYEXP_ZEROIZE_EN is defined.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (key_i[255:64]), size 01 → ready_o after 47 edges; key_words_o[3] = e98ba06f448c773c8ecc720401002202.
- 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, size 11 → ready_o after 53 edges; key_words_o[1] = fe4890d1e6188d0b046df344706c631e. Repeat with size 10 for an identical result.
- 256-bit run, then 128-bit start from DONE:
  - ready_o drops on the LOAD edge and rises after 41 edges.
  - Slots 4:1 are zero when AES_KEYEXP_ZEROIZE_EN is defined, and hold the 256-bit values when it is undefined.
- Second start 10 cycles into a 256-bit run, with the 128-bit FIPS key → ready_o after 41 edges from the second start; slot 5 = d014f9a8...0ca6.
- reset driven low mid-RUN, between clock edges → busy_o, ready_o and key_words_o clear immediately. After release, a fresh start completes normally.
